// File: rtl/nebula_vc_fifo.sv
// Virtual-channel FWFT FIFO: NUM_VC independent DEPTH x WIDTH queues behind one write and one read port.
// Define NEBULA_VC_FIFO_STATS_EN to add sticky overflow/underflow flags and per-VC peak occupancy.
module nebula_vc_fifo #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int NUM_VC    = 4,
  parameter int AF_THRESH = 6,
  localparam int VW = $clog2(NUM_VC),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [VW-1:0]        push_vc,
  input  logic [WIDTH-1:0]     din,
  input  logic                 pop,
  input  logic [VW-1:0]        rd_vc,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  output logic [NUM_VC-1:0]    full,
  output logic [NUM_VC-1:0]    empty,
  output logic [NUM_VC-1:0]    almost_full,
  output logic [NUM_VC*LW-1:0] level
`ifdef NEBULA_VC_FIFO_STATS_EN
  ,
  output logic [NUM_VC-1:0]    ovf_err,
  output logic [NUM_VC-1:0]    udf_err,
  output logic [NUM_VC*LW-1:0] peak_lvl
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
  // One extra bit so the range check stays meaningful when NUM_VC is a power of two.
  localparam logic [VW:0]   NVC_L   = (VW + 1)'(NUM_VC);

  logic [WIDTH-1:0] r_mem    [NUM_VC][DEPTH];
  logic [PW-1:0]    r_wr_ptr [NUM_VC];
  logic [PW-1:0]    r_rd_ptr [NUM_VC];
  logic [LW-1:0]    r_level  [NUM_VC];

  logic              w_push_vc_ok;
  logic              w_rd_vc_ok;
  logic              w_pop_ok;
  logic              w_push_ok;
  logic [NUM_VC-1:0] w_wr_en;
  logic [NUM_VC-1:0] w_rd_en;
  logic [LW-1:0]     w_lvl_nxt [NUM_VC];

  assign w_push_vc_ok = ({1'b0, push_vc} < NVC_L);
  assign w_rd_vc_ok   = ({1'b0, rd_vc} < NVC_L);
  assign w_pop_ok     = pop && w_rd_vc_ok && (r_level[rd_vc] != '0);
  // A full VC still takes a write when the same cycle pops its head.
  assign w_push_ok    = push && w_push_vc_ok &&
                        ((r_level[push_vc] != DEPTH_L) || (w_pop_ok && (rd_vc == push_vc)));

  assign dout       = w_rd_vc_ok ? r_mem[rd_vc][r_rd_ptr[rd_vc]] : '0;
  assign dout_valid = w_rd_vc_ok && (r_level[rd_vc] != '0);

  always_comb begin
    w_wr_en     = '0;
    w_rd_en     = '0;
    full        = '0;
    empty       = '0;
    almost_full = '0;
    level       = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      w_lvl_nxt[v] = r_level[v];
      w_wr_en[v]   = w_push_ok && (push_vc == VW'(v));
      w_rd_en[v]   = w_pop_ok && (rd_vc == VW'(v));
      if (w_wr_en[v] && !w_rd_en[v]) begin
        w_lvl_nxt[v] = r_level[v] + LW'(1);
      end else if (!w_wr_en[v] && w_rd_en[v]) begin
        w_lvl_nxt[v] = r_level[v] - LW'(1);
      end
      full[v]             = (r_level[v] == DEPTH_L);
      empty[v]            = (r_level[v] == '0);
      almost_full[v]      = (r_level[v] >= AF_L);
      level[v*LW +: LW]   = r_level[v];
    end
  end

  // Storage is deliberately not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem[push_vc][r_wr_ptr[push_vc]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_wr_ptr[v] <= '0;
        r_rd_ptr[v] <= '0;
        r_level[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_wr_en[v]) r_wr_ptr[v] <= r_wr_ptr[v] + PW'(1);
        if (w_rd_en[v]) r_rd_ptr[v] <= r_rd_ptr[v] + PW'(1);
        r_level[v] <= w_lvl_nxt[v];
      end
    end
  end

`ifdef NEBULA_VC_FIFO_STATS_EN
  logic [LW-1:0] r_peak [NUM_VC];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= '0;
      udf_err <= '0;
      for (int v = 0; v < NUM_VC; v++) r_peak[v] <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (push && w_push_vc_ok && !w_push_ok && (push_vc == VW'(v))) ovf_err[v] <= 1'b1;
        if (pop && w_rd_vc_ok && !w_pop_ok && (rd_vc == VW'(v)))       udf_err[v] <= 1'b1;
        if (w_lvl_nxt[v] > r_peak[v]) r_peak[v] <= w_lvl_nxt[v];
      end
    end
  end

  always_comb begin
    peak_lvl = '0;
    for (int v = 0; v < NUM_VC; v++) peak_lvl[v*LW +: LW] = r_peak[v];
  end
`endif

endmodule
